// File: rtl/rr_reg_arbiter_pkg.sv
// Shared types and helpers for the round-robin register arbiter.
// Holds the FSM state encoding and a constant-safe clog2.
package rr_reg_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Never returns less than 1 so single-bit fields stay legal.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/rr_reg_arbiter_pick.sv
// Combinational round-robin picker: first set bit of elig at or after ptr,
// wrapping modulo N.
module rr_pick
   import rr_reg_arbiter_pkg::*;
#(
   parameter int N = 4
)(
   input  logic [N-1:0]          elig,
   input  logic [clog2(N)-1:0]   ptr,
   output logic                  found,
   output logic [clog2(N)-1:0]   idx
);

   localparam int PW = clog2(N);

   // Walk the offsets backwards so the smallest offset wins last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         int c;
         c = (int'(ptr) + k) % N;
         if (elig[PW'(c)]) begin
            found = 1'b1;
            idx   = PW'(c);
         end
      end
   end

endmodule

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter owning one shared W-bit register, with bounded
// per-owner burst locking and registered one-hot grant.
module rr_reg_arbiter
   import rr_reg_arbiter_pkg::*;
#(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int MAX_LOCK = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N-1:0]          req,
   input  logic [N-1:0]          lock,
   input  logic [N*W-1:0]        wdata,
   output logic [N-1:0]          gnt,
   output logic [W-1:0]          q,
   output logic [clog2(N)-1:0]   owner,
   output logic                  busy
);

   localparam int PW = clog2(N);
   localparam int CW = clog2(MAX_LOCK + 1);

   state_t          r_state;
   state_t          w_next;
   logic [N-1:0]    r_gnt;
   logic [W-1:0]    r_q;
   logic [PW-1:0]   r_owner;
   logic [PW-1:0]   r_ptr;
   logic [CW-1:0]   r_lock_cnt;

   logic [N-1:0]    w_elig;
   logic            w_found;
   logic [PW-1:0]   w_idx;
   logic            w_hold;
   logic            w_grant;
   logic            w_release;
   logic [N-1:0]    w_onehot;
   logic [PW-1:0]   w_ptr_nxt;

   // The current grantee is masked so it cannot win back-to-back unlocked.
   assign w_elig = req & ~r_gnt;

   rr_pick #(.N(N)) u_pick (
      .elig  (w_elig),
      .ptr   (r_ptr),
      .found (w_found),
      .idx   (w_idx)
   );

   assign w_hold    = (r_state != IDLE) && req[r_owner] &&
                      lock[r_owner] && (r_lock_cnt < CW'(MAX_LOCK));
   assign w_grant   = !w_hold && w_found;
   assign w_release = !w_hold && !w_found;
   assign w_onehot  = N'(1) << w_idx;
   assign w_ptr_nxt = (int'(w_idx) == N - 1) ? '0 : w_idx + PW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:   w_next = w_found ? GRANT : IDLE;
         GRANT,
         LOCKED: begin
            if (w_hold)       w_next = LOCKED;
            else if (w_found) w_next = GRANT;
            else              w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt      <= '0;
         r_q        <= '0;
         r_owner    <= '0;
         r_ptr      <= '0;
         r_lock_cnt <= '0;
      end else begin
         unique case (1'b1)
            w_hold: begin
               r_q        <= wdata[int'(r_owner)*W +: W];
               r_lock_cnt <= r_lock_cnt + CW'(1);
            end
            w_grant: begin
               r_gnt      <= w_onehot;
               r_q        <= wdata[int'(w_idx)*W +: W];
               r_owner    <= w_idx;
               r_ptr      <= w_ptr_nxt;
               r_lock_cnt <= CW'(1);
            end
            w_release: begin
               r_gnt      <= '0;
               r_lock_cnt <= '0;
            end
            default: ;
         endcase
      end
   end

   assign gnt   = r_gnt;
   assign q     = r_q;
   assign owner = r_owner;
   assign busy  = (r_state != IDLE);

endmodule

// File: doc/rr_reg_arbiter.md
# rr_reg_arbiter

Round-robin arbiter that shares one W-bit edge-triggered storage register among N requesters. Each cycle it picks at most one requester, writes that requester's data into the shared register, and signals the write with a registered one-hot grant. A granted requester can lock the register for a bounded burst of consecutive writes. The block sits between lab-level requester logic and the shared flip-flop storage, and is the only writer of that storage.

## Interface
- N, default 4: number of requesters (2..8)
- W, default 8: width of the shared register
- MAX_LOCK, default 8: maximum consecutive writes one owner may perform (≥1)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  N  per-requester write request; held until the requester sees its gnt bit
- lock  in  N  per-requester burst request; only honoured for the current owner
- wdata  in  N*W  write data; requester i occupies bits [i*W +: W]
- gnt  out  N  registered one-hot grant; gnt[i]=1 means q was written from wdata[i] at the edge that started this cycle
- q  out  W  shared register contents
- owner  out  clog2(N)  index of the last granted requester
- busy  out  1  high when state ≠ IDLE

## Operation
- Reset values: state IDLE, gnt=0, q=0, owner=0, busy=0, ptr=0, lock_cnt=0.
- Eligibility: elig = req & ~gnt. A requester that is granted in the current cycle cannot win the next arbitration unless it stays under lock.
- Pick: the first set bit of elig, searched from ptr upward with wrap-around modulo N. When a winner w is chosen: ptr ← (w+1) mod N.
- States:
  - **IDLE**: if elig≠0, the winner w takes effect at the edge: gnt←onehot(w), q←wdata[w], owner←w, lock_cnt←1, and the state goes to GRANT. Otherwise gnt stays 0.
  - **GRANT / LOCKED**: if req[owner] & lock[owner] & (lock_cnt < MAX_LOCK): go to LOCKED, keep gnt, q←wdata[owner], lock_cnt++, ptr unchanged.
    - Otherwise release. If elig≠0, grant the new winner (enter GRANT as above). Else gnt←0 and go to IDLE.
- Forced release at MAX_LOCK: the owner gets no grant in the following cycle, because it is masked. Other eligible requesters win first.
- A lock asserted by a non-owner is ignored.
- Width rules:
  - lock_cnt is clog2(MAX_LOCK+1) bits and saturates at MAX_LOCK.
  - ptr and owner are clog2(N) bits, and wrap explicitly for non-power-of-two N.
- Asserting rst mid-burst clears everything to the reset values immediately. No write occurs on the edge where rst is high.

## Timing
- Latency: a req sampled at edge k yields gnt and the updated q during cycle k+1, if the requester wins at edge k.
- Requester protocol: see gnt[i] in cycle k+1, then deassert req[i] (or change wdata) before edge k+2 unless continuing under lock.
- Throughput:
  - One write per cycle overall.
  - A lone unlocked requester that keeps req high is granted every other cycle.
  - Continuously requesting unlocked requesters rotate with one grant per cycle.
- Outputs gnt, q, owner and busy are all register outputs, with no combinational path from inputs.

## Structure
- Shared package holds:
  - state encoding: IDLE=0, GRANT=1, LOCKED=2
  - the clog2 helper
- Sub-module **rr_pick**: purely combinational. Inputs are elig[N] and ptr; outputs are found (1 bit) and idx (clog2(N) bits).
- The top level holds the FSM, ptr, lock_cnt, and the q/gnt/owner registers.

## Test plan
All scenarios use N=4, W=8.
- **Reset mid-burst**: assert rst while gnt=0010 in LOCKED → gnt=0, q=00, owner=0, busy=0 before the next clock edge.
- **Single write**: req=0001, wdata0=A5 at edge 0 → cycle 1: gnt=0001, q=A5, owner=0. Requester drops req → cycle 2: gnt=0, busy=0, q stays A5.
- **Rotation**: req=1111 held with no lock, straight after reset → grants 0,1,2,3,0 on consecutive cycles. q follows wdata0..3.
- **Lock cap**: MAX_LOCK=4, req=lock=0100 held, wdata2 = 10,11,12,… → gnt=0100 for exactly 4 cycles with q=10..13, then one cycle of gnt=0, then gnt=0100 again.
- **Lock handoff**: requester 1 is locked and requester 3 is waiting. lock1 drops after 2 writes → the next cycle has gnt=1000 and q=wdata3.
- **Pointer wrap**: last grant to 2 (ptr=3), then req=1001 held → gnt=1000, then 0001.
